usr_burst: RTL and testbench

Parametrised universal shift register that replaces the fixed 4-bit version. It supports WIDTH-bit hold, logical shifts, rotates, arithmetic shift, parallel load and synchronous clear. It also has a burst engine that runs a shift or rotate for a programmed number of steps under a start/busy/done handshake. It sits in the register library as the common serialiser/aligner for datapath blocks.

---
 rtl/usr_pkg.sv | 28 ++
 rtl/usr_step.sv | 31 +++
 rtl/usr_burst.sv | 99 +++++++++
 tb/tb_usr_burst.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, burst FSM
// states and the helper that picks out which ops may run as a burst.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROTR = 3'b100,
        OP_ROTL = 3'b101,
        OP_ASHR = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Only shifts and rotates are meaningful to repeat; load/clear/hold are one-shot.
    function automatic logic is_burst_op(op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROTR) ||
               (op == OP_ROTL) || (op == OP_ASHR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step next value of the shift register for one op.
// Shared by the direct path and every step of a burst.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_HOLD: q_next = q;
            OP_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            OP_LOAD: q_next = din;
            OP_ROTR: q_next = {q[0], q[WIDTH-1:1]};
            OP_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASHR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_CLR:  q_next = '0;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// Parametrised universal shift register with a burst engine that repeats a
// shift/rotate for a programmed number of steps under a start/busy/done handshake.
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_e             state;
    state_e             state_next;
    op_e                op_r;
    op_e                step_op;
    logic [CNT_W-1:0]   rem;
    logic [WIDTH-1:0]   q_next;
    logic               latch_burst;
    logic               dec_rem;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (step_op),
        .q      (q),
        .din    (din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_next)
    );

    // The accepting edge of a burst only latches op/cnt; q moves from the next edge on.
    always_comb begin
        state_next  = state;
        step_op     = OP_HOLD;
        latch_burst = 1'b0;
        dec_rem     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && is_burst_op(op_e'(op))) begin
                    latch_burst = 1'b1;
                    state_next  = (cnt != '0) ? ST_RUN : ST_DONE;
                end else begin
                    step_op = op_e'(op);
                end
            end
            ST_RUN: begin
                step_op = op_r;
                dec_rem = 1'b1;
                if (rem == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op_r  <= OP_HOLD;
            rem   <= '0;
            q     <= '0;
        end else if (en) begin
            state <= state_next;
            q     <= q_next;
            if (latch_burst) begin
                op_r <= op_e'(op);
                rem  <= cnt;
            end else if (dec_rem) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_usr_burst.sv
// Self-checking bench for usr_burst: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the register.
module tb_usr_burst;
    import usr_pkg::*;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  din = '0;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int checks = 0;
    int passes = 0;

    usr_burst #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .op     (op),
        .din    (din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .cnt    (cnt),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Behavioural model: register value, steps still owed by a burst, and a pending done cycle.
    logic [W-1:0] m_q = '0;
    logic [2:0]   m_op = 3'b000;
    int           m_left = 0;
    bit           m_done = 1'b0;

    function automatic logic [W-1:0] model_step(logic [2:0] o, logic [W-1:0] v,
                                                logic [W-1:0] d, logic sl, logic sr);
        logic [W-1:0] slw;
        slw = '0;
        slw[W-1] = sl;
        case (o)
            3'b001:  return (v >> 1) | slw;
            3'b010:  return (v << 1) | W'(sr);
            3'b011:  return d;
            3'b100:  return (v >> 1) | (v << (W - 1));
            3'b101:  return (v << 1) | (v >> (W - 1));
            3'b110:  return W'($signed(v) >>> 1);
            3'b111:  return '0;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = '0;
            m_op = 3'b000;
            m_left = 0;
            m_done = 1'b0;
        end else if (en) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                m_q = model_step(m_op, m_q, din, sin_l, sin_r);
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (start && (op inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110})) begin
                m_op = op;
                m_left = int'(cnt);
                if (cnt == '0) m_done = 1'b1;
            end else begin
                m_q = model_step(op, m_q, din, sin_l, sin_r);
            end
        end
    end

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            compare("model q", 32'(q), 32'(m_q));
            compare("model busy", 32'(busy), 32'(m_left > 0));
            compare("model done", 32'(done), 32'(m_done));
            compare("model sout_l", 32'(sout_l), 32'(m_q[W-1]));
            compare("model sout_r", 32'(sout_r), 32'(m_q[0]));
        end
    end

    // Drive one cycle of inputs just after a falling edge, return at the next falling edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] d, input logic s,
                                 input logic [CW-1:0] c, input logic sl, input logic sr,
                                 input logic e);
        op = o;
        din = d;
        start = s;
        cnt = c;
        sin_l = sl;
        sin_r = sr;
        en = e;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] eq,
                               input logic eb, input logic ed);
        compare({name, " q"}, 32'(q), 32'(eq));
        compare({name, " busy"}, 32'(busy), 32'(eb));
        compare({name, " done"}, 32'(done), 32'(ed));
    endtask

    task automatic runBurst(input logic [2:0] o, input logic [W-1:0] init, input int k,
                            input logic sl, input logic sr, input logic [W-1:0] expq,
                            input string name);
        applyStimulus(OP_LOAD, init, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(o, '0, 1'b1, CW'(k), sl, sr, 1'b1);
        for (int i = 0; i < k; i++) applyStimulus(OP_HOLD, '0, 1'b0, '0, sl, sr, 1'b1);
        checkOutput(name, expq, 1'b0, 1'b1);
        applyStimulus(OP_HOLD, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput({name, " idle"}, expq, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        applyStimulus(OP_LOAD, 8'hA5, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("load A5", 8'hA5, 1'b0, 1'b0);
        applyStimulus(OP_SHR, 8'h00, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("shr", 8'hD2, 1'b0, 1'b0);
        applyStimulus(OP_SHL, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("shl", 8'hA4, 1'b0, 1'b0);
        applyStimulus(OP_LOAD, 8'h80, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_ASHR, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("ashr", 8'hC0, 1'b0, 1'b0);
        applyStimulus(OP_CLR, 8'hFF, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("clear", 8'h00, 1'b0, 1'b0);
        applyStimulus(OP_LOAD, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        checkOutput("load with start", 8'h00, 1'b0, 1'b0);

        // Burst rotl x3 from 0x81, with load/din driven during RUN to show they are ignored.
        applyStimulus(OP_LOAD, 8'h81, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_ROTL, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        checkOutput("rotl accept", 8'h81, 1'b1, 1'b0);
        applyStimulus(OP_LOAD, 8'hFF, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        checkOutput("rotl step1", 8'h03, 1'b1, 1'b0);
        applyStimulus(OP_LOAD, 8'hFF, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("rotl step2", 8'h06, 1'b1, 1'b0);
        applyStimulus(OP_SHR, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        checkOutput("rotl step3", 8'h0C, 1'b0, 1'b1);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("rotl idle", 8'h0C, 1'b0, 1'b0);

        // Zero-length burst.
        applyStimulus(OP_LOAD, 8'h3C, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_SHR, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        checkOutput("cnt0 done", 8'h3C, 1'b0, 1'b1);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("cnt0 idle", 8'h3C, 1'b0, 1'b0);

        // Burst shl x4 with en low for two cycles mid-burst and start pulsed during RUN.
        applyStimulus(OP_LOAD, 8'h01, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_SHL, 8'h00, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("gate step1", 8'h03, 1'b1, 1'b0);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(OP_CLR, 8'h00, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        checkOutput("gate frozen", 8'h03, 1'b1, 1'b0);
        applyStimulus(OP_CLR, 8'h00, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
        checkOutput("gate step2", 8'h07, 1'b1, 1'b0);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("gate final", 8'h1F, 1'b0, 1'b1);
        applyStimulus(OP_CLR, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("done held", 8'h1F, 1'b0, 1'b1);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("gate idle", 8'h1F, 1'b0, 1'b0);

        // Bursts longer than WIDTH: shifts saturate, rotates wrap.
        runBurst(OP_SHR, 8'h5A, 12, 1'b1, 1'b0, 8'hFF, "shr x12");
        runBurst(OP_ROTL, 8'h81, 9, 1'b0, 1'b0, 8'h03, "rotl x9");
        runBurst(OP_ASHR, 8'h80, 10, 1'b0, 1'b0, 8'hFF, "ashr x10");
        runBurst(OP_ROTR, 8'h01, 3, 1'b0, 1'b0, 8'h20, "rotr x3");

        // Reset mid-burst, asserted between clock edges.
        applyStimulus(OP_LOAD, 8'hF0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_ROTR, 8'h00, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("rotr pre-reset", 8'h1E, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("async reset", 8'h00, 1'b0, 1'b0);
        compare("async reset sout_l", 32'(sout_l), 32'd0);
        #1 rst = 1'b0;
        applyStimulus(OP_LOAD, 8'h55, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("load after reset", 8'h55, 1'b0, 1'b0);
        applyStimulus(OP_HOLD, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("hold after reset", 8'h55, 1'b0, 1'b0);

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
